// File: rtl/register_shift_universal.sv
// Universal shift register: hold, shift up/down, parallel load, word counter.
// Optional rotate input when SHIFT_ROTATE_EN is defined.
module register_shift_universal #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             serial_in_lsb,
  input  logic             serial_in_msb,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic [CW-1:0]    shift_count,
  output logic             word_done
`ifdef SHIFT_ROTATE_EN
  ,
  input  logic             rotate
`endif
);

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DN   = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift;
  logic             fill_lsb;
  logic             fill_msb;

  always_comb begin
    fill_lsb = serial_in_lsb;
    fill_msb = serial_in_msb;
`ifdef SHIFT_ROTATE_EN
    if (rotate) begin
      fill_lsb = q_q[WIDTH-1];
      fill_msb = q_q[0];
    end
`endif
  end

  always_comb begin
    q_d    = q_q;
    so_d   = so_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    shift  = 1'b0;
    if (enable) begin
      case (mode)
        M_HOLD: ;
        M_UP: begin
          so_d  = q_q[WIDTH-1];
          q_d   = {q_q[WIDTH-2:0], fill_lsb};
          shift = 1'b1;
        end
        M_DN: begin
          so_d  = q_q[0];
          q_d   = {fill_msb, q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        M_LOAD: begin
          q_d   = parallel_in;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
    // a full word of shifts wraps the counter and pulses done once
    if (shift) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q_q    <= '0;
      so_q   <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      so_q   <= so_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign parallel_out = q_q;
  assign serial_out   = so_q;
  assign shift_count  = cnt_q;
  assign word_done    = done_q;

endmodule

// File: tb/tb_register_shift_universal.sv
// Bench for register_shift_universal: vector table, corner sequences,
// and random stimulus against a word-level reference model.
module tb_register_shift_universal;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clear_n;
  logic          en, sl, sm;
  logic [1:0]    md;
  logic [W-1:0]  pin, pout;
  logic          so, done;
  logic [CW-1:0] cnt;
  logic          rot;

  logic       e4, s4l, s4m, so4, d4;
  logic [1:0] m4;
  logic [3:0] p4, po4;
  logic [2:0] c4;

  register_shift_universal #(.WIDTH(W)) dut (
    .clk(clk), .clear_n(clear_n), .enable(en), .mode(md),
    .serial_in_lsb(sl), .serial_in_msb(sm), .parallel_in(pin),
    .parallel_out(pout), .serial_out(so), .shift_count(cnt),
    .word_done(done)
`ifdef SHIFT_ROTATE_EN
    , .rotate(rot)
`endif
  );

  register_shift_universal #(.WIDTH(4)) dut4 (
    .clk(clk), .clear_n(clear_n), .enable(e4), .mode(m4),
    .serial_in_lsb(s4l), .serial_in_msb(s4m), .parallel_in(p4),
    .parallel_out(po4), .serial_out(so4), .shift_count(c4),
    .word_done(d4)
`ifdef SHIFT_ROTATE_EN
    , .rotate(1'b0)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference state: value, last bit out, shifts since load/clear
  int m_q, m_so, m_n, m_done;

  typedef struct {
    logic       e;
    logic [1:0] m;
    logic       si;
    logic [7:0] p;
    logic [7:0] q;
    logic       o;
    logic [3:0] c;
    logic       d;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_so = 0; m_n = 0; m_done = 0;
  endtask

  task automatic model_step();
    int fl, fm;
    fl = int'(sl);
    fm = int'(sm);
`ifdef SHIFT_ROTATE_EN
    if (rot) begin
      fl = m_q / (1 << (W-1));
      fm = m_q % 2;
    end
`endif
    m_done = 0;
    if (en) begin
      if (md == 2'b01) begin
        m_so = m_q / (1 << (W-1));
        m_q  = (m_q * 2 + fl) % (1 << W);
        m_n++;
        m_done = (m_n % W == 0) ? 1 : 0;
      end else if (md == 2'b10) begin
        m_so = m_q % 2;
        m_q  = m_q / 2 + fm * (1 << (W-1));
        m_n++;
        m_done = (m_n % W == 0) ? 1 : 0;
      end else if (md == 2'b11) begin
        m_q = int'(pin);
        m_n = 0;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string t);
    chk({t, "_q"}, 64'(pout), 64'(m_q));
    chk({t, "_so"}, 64'(so), 64'(m_so));
    chk({t, "_cnt"}, 64'(cnt), 64'(m_n % W));
    chk({t, "_done"}, 64'(done), 64'(m_done));
  endtask

  task automatic drive(input logic e, input logic [1:0] m,
                       input logic l, input logic s,
                       input logic [W-1:0] p, input string t);
    en = e; md = m; sl = l; sm = s; pin = p;
    cyc();
    check_model(t);
  endtask

  initial begin
    int nd;
    logic [3:0] e16q [4];
    logic [2:0] e16c [4];
    logic       e16s [4];

    vt[0] = '{1'b1, 2'b11, 1'b0, 8'hA5, 8'hA5, 1'b0, 4'd0, 1'b0};
    vt[1] = '{1'b1, 2'b10, 1'b0, 8'h00, 8'h52, 1'b1, 4'd1, 1'b0};
    vt[2] = '{1'b1, 2'b10, 1'b0, 8'h00, 8'h29, 1'b0, 4'd2, 1'b0};
    vt[3] = '{1'b1, 2'b10, 1'b0, 8'h00, 8'h14, 1'b1, 4'd3, 1'b0};
    vt[4] = '{1'b1, 2'b10, 1'b0, 8'h00, 8'h0A, 1'b0, 4'd4, 1'b0};
    vt[5] = '{1'b1, 2'b10, 1'b0, 8'h00, 8'h05, 1'b0, 4'd5, 1'b0};
    vt[6] = '{1'b1, 2'b10, 1'b0, 8'h00, 8'h02, 1'b1, 4'd6, 1'b0};
    vt[7] = '{1'b1, 2'b10, 1'b0, 8'h00, 8'h01, 1'b0, 4'd7, 1'b0};
    vt[8] = '{1'b1, 2'b10, 1'b0, 8'h00, 8'h00, 1'b1, 4'd0, 1'b1};
    vt[9] = '{1'b0, 2'b10, 1'b1, 8'h00, 8'h00, 1'b1, 4'd0, 1'b0};

    clear_n = 1'b0;
    en = 0; md = 0; sl = 0; sm = 0; pin = 0; rot = 0;
    e4 = 0; m4 = 0; s4l = 0; s4m = 0; p4 = 0;
    model_reset();
    #2;
    check_model("reset");
    chk("reset4_q", 64'(po4), 64'd0);
    @(negedge clk);
    clear_n = 1'b1;
    @(posedge clk);
    #1;

    // width-4 fill toward MSB with 1,1,1,0
    e16q[0] = 4'h1; e16q[1] = 4'h3; e16q[2] = 4'h7; e16q[3] = 4'hE;
    e16c[0] = 3'd1; e16c[1] = 3'd2; e16c[2] = 3'd3; e16c[3] = 3'd0;
    e16s[0] = 1'b1; e16s[1] = 1'b1; e16s[2] = 1'b1; e16s[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e4 = 1'b1; m4 = 2'b01; s4l = e16s[i];
      cyc();
      chk($sformatf("w4_q%0d", i), 64'(po4), 64'(e16q[i]));
      chk($sformatf("w4_so%0d", i), 64'(so4), 64'd0);
      chk($sformatf("w4_cnt%0d", i), 64'(c4), 64'(e16c[i]));
      chk($sformatf("w4_done%0d", i), 64'(d4), (i == 3) ? 64'd1 : 64'd0);
    end
    e4 = 1'b0;
    cyc();
    chk("w4_done_clr", 64'(d4), 64'd0);
    chk("w4_hold_q", 64'(po4), 64'hE);

    // load 0xA5 then shift out toward LSB
    for (int i = 0; i < 10; i++) begin
      en = vt[i].e; md = vt[i].m; sl = vt[i].si; sm = vt[i].si;
      pin = vt[i].p;
      cyc();
      chk($sformatf("tbl%0d_q", i), 64'(pout), 64'(vt[i].q));
      chk($sformatf("tbl%0d_so", i), 64'(so), 64'(vt[i].o));
      chk($sformatf("tbl%0d_cnt", i), 64'(cnt), 64'(vt[i].c));
      chk($sformatf("tbl%0d_done", i), 64'(done), 64'(vt[i].d));
    end

    // load mid-word restarts the count
    for (int i = 0; i < 5; i++)
      drive(1'b1, 2'b01, 1'($urandom), 1'b0, '0, "mid");
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C, "load3c");
    chk("load3c_cnt", 64'(cnt), 64'd0);
    chk("load3c_done", 64'(done), 64'd0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'($urandom),
            1'($urandom), '0, "after3c");
      if (done) nd++;
    end
    chk("after3c_pulses", 64'(nd), 64'd1);

    // enable toggling: only accepted shifts count
    nd = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'((i % 2) == 0), 2'b10, 1'b0, 1'($urandom), '0, "entog");
      if (done) nd++;
      if (i == 14) chk("entog_done14", 64'(done), 64'd1);
    end
    chk("entog_pulses", 64'(nd), 64'd1);

    // asynchronous clear between edges
    for (int i = 0; i < 3; i++)
      drive(1'b1, 2'b01, 1'b1, 1'b0, '0, "preclr");
    @(negedge clk);
    clear_n = 1'b0;
    #1;
    model_reset();
    check_model("aclr");
    #1;
    clear_n = 1'b1;
    drive(1'b1, 2'b01, 1'b1, 1'b0, '0, "postclr");
    chk("postclr_cnt", 64'(cnt), 64'd1);

`ifdef SHIFT_ROTATE_EN
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h81, "rotload");
    rot = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b01, 1'b0, 1'b0, '0, "rot");
      if (done) nd++;
    end
    chk("rot_q", 64'(pout), 64'h81);
    chk("rot_pulses", 64'(nd), 64'd1);
    rot = 1'b0;
`endif

    for (int i = 0; i < 400; i++) begin
`ifdef SHIFT_ROTATE_EN
      rot = 1'($urandom_range(0, 3) == 0);
`endif
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom),
            1'($urandom), 1'($urandom), W'($urandom), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
